// File: rtl/trace_pkg.sv
// Shared definitions for the instruction trace capture block.
// Holds the control state encoding, halt-reason codes and the bit offsets
// of each field inside a trace entry (LSB first: rf_wdata, rf_waddr, rf_we,
// commit_instr, commit_pc, optional timestamp).
// Build option: TRACE_TIMESTAMP_EN prepends a 16-bit cycle stamp to entries.
package trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    HR_NONE       = 2'd0,
    HR_LIMIT      = 2'd1,
    HR_HALT_INSTR = 2'd2,
    HR_FULL       = 2'd3
  } halt_reason_e;

`ifdef TRACE_TIMESTAMP_EN
  localparam int unsigned TS_W = 16;
`else
  localparam int unsigned TS_W = 0;
`endif

  localparam int unsigned INSTR_W   = 32;
  localparam int unsigned WADDR_W   = 5;
  localparam int unsigned OFF_WDATA = 0;

  // Field offsets depend on XLEN, so they are computed per instance.
  function automatic int unsigned off_waddr(input int unsigned xlen);
    return xlen;
  endfunction

  function automatic int unsigned off_we(input int unsigned xlen);
    return xlen + WADDR_W;
  endfunction

  function automatic int unsigned off_instr(input int unsigned xlen);
    return xlen + WADDR_W + 1;
  endfunction

  function automatic int unsigned off_pc(input int unsigned xlen);
    return xlen + WADDR_W + 1 + INSTR_W;
  endfunction

  function automatic int unsigned off_ts(input int unsigned xlen);
    return 2 * xlen + WADDR_W + 1 + INSTR_W;
  endfunction

  function automatic int unsigned entry_w(input int unsigned xlen);
    return off_ts(xlen) + TS_W;
  endfunction

endpackage

// File: rtl/trace_capture_if.sv
// Commit bus and drain port of the trace capture block.
// master: core/reader side (drives commit fields and rd_en).
// slave : trace_capture side (returns rd_valid/rd_data).
// Entry width follows TRACE_TIMESTAMP_EN through trace_pkg::entry_w.
interface trace_capture_if #(
  parameter int unsigned XLEN = 32
);
  import trace_pkg::*;

  localparam int unsigned ENTRY_W = entry_w(XLEN);

  logic               commit_valid;
  logic [XLEN-1:0]    commit_pc;
  logic [31:0]        commit_instr;
  logic               rf_we;
  logic [4:0]         rf_waddr;
  logic [XLEN-1:0]    rf_wdata;
  logic               rd_en;
  logic               rd_valid;
  logic [ENTRY_W-1:0] rd_data;

  modport master (
    output commit_valid, commit_pc, commit_instr, rf_we, rf_waddr, rf_wdata, rd_en,
    input  rd_valid, rd_data
  );

  modport slave (
    input  commit_valid, commit_pc, commit_instr, rf_we, rf_waddr, rf_wdata, rd_en,
    output rd_valid, rd_data
  );

endinterface

// File: rtl/trace_fifo.sv
// Trace entry storage: circular buffer with occupancy count and a
// registered, latency-1 read port.
// Ports: push/push_data write side; pop read request; rd_valid/rd_data
// registered read result; count occupancy; drop_c/overwrite_c flag a push
// that meets a full buffer with no simultaneous pop (drop when WRAP=0,
// overwrite-oldest when WRAP=1).
module trace_fifo #(
  parameter int unsigned WIDTH = 102,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WRAP  = 0
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic                   rd_valid,
  output logic [WIDTH-1:0]       rd_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   drop_c,
  output logic                   overwrite_c
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             rd_valid_q, rd_valid_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             full_c, pop_fire_c, wr_fire_c;

  // Pointer/count update; a pop frees a slot so full+push+pop never drops.
  always_comb begin
    full_c      = (count_q == CNT_W'(DEPTH));
    pop_fire_c  = pop && (count_q != '0);
    drop_c      = push && full_c && !pop_fire_c && (WRAP == 0);
    overwrite_c = push && full_c && !pop_fire_c && (WRAP != 0);
    wr_fire_c   = push && !drop_c;

    wr_ptr_d = wr_fire_c ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    // Overwrite lands on the oldest slot, so the read pointer skips past it.
    rd_ptr_d = (pop_fire_c || overwrite_c) ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

    count_d = count_q;
    if (wr_fire_c && !overwrite_c && !pop_fire_c) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop_fire_c && !wr_fire_c) begin
      count_d = count_q - CNT_W'(1);
    end

    rd_valid_d = pop_fire_c;
    rd_data_d  = pop_fire_c ? mem_q[rd_ptr_q] : rd_data_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // Storage array is intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_fire_c) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign count    = count_q;

endmodule

// File: rtl/trace_capture.sv
// Instruction trace capture: records retiring instructions and their
// register writes into a trace buffer during a capture run.
// Ports: clk, rstn (async active-low), arm (start/restart a run),
// bus (commit input + drain port, trace_capture_if.slave), count
// (buffer occupancy), running, halt_reason, overflow (sticky overwrite).
// Build option: TRACE_TIMESTAMP_EN adds the run cycle count at push time
// as the top field of each entry.
module trace_capture
  import trace_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned CYCLE_LIMIT = 500,
  parameter logic [31:0] HALT_INSTR  = 32'hFFFF_FFFF,
  parameter int unsigned WRAP        = 0
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   arm,
  trace_capture_if.slave         bus,
  output logic [$clog2(DEPTH):0] count,
  output logic                   running,
  output logic [1:0]             halt_reason,
  output logic                   overflow
);

  localparam int unsigned ENTRY_W = entry_w(XLEN);
  localparam int unsigned O_WADDR = off_waddr(XLEN);
  localparam int unsigned O_WE    = off_we(XLEN);
  localparam int unsigned O_INSTR = off_instr(XLEN);
  localparam int unsigned O_PC    = off_pc(XLEN);
  localparam int unsigned LIM_W   = $clog2(CYCLE_LIMIT + 1);
  // Counter is at least 16 bits so it can also feed the timestamp field.
  localparam int unsigned CYC_W   = (LIM_W > 16) ? LIM_W : 16;

  state_e         state_q, state_d;
  halt_reason_e   halt_reason_q, halt_reason_d;
  logic [CYC_W-1:0] cyc_q, cyc_d, cyc_inc_c;
  logic           overflow_q, overflow_d;
  logic           running_q, running_d;
  logic           push_c, drop_c, overwrite_c;
  logic [ENTRY_W-1:0] entry_c;
  logic           fifo_rd_valid;
  logic [ENTRY_W-1:0] fifo_rd_data;

  assign push_c    = (state_q == ST_RUN) && bus.commit_valid;
  assign cyc_inc_c = cyc_q + CYC_W'(1);

  // Entry assembly; a write to x0 is recorded as no write.
  always_comb begin
    entry_c = '0;
    entry_c[OFF_WDATA +: XLEN]  = bus.rf_wdata;
    entry_c[O_WADDR +: WADDR_W] = bus.rf_waddr;
    entry_c[O_WE]               = bus.rf_we && (bus.rf_waddr != 5'd0);
    entry_c[O_INSTR +: INSTR_W] = bus.commit_instr;
    entry_c[O_PC +: XLEN]       = bus.commit_pc;
`ifdef TRACE_TIMESTAMP_EN
    entry_c[off_ts(XLEN) +: TS_W] = cyc_q[TS_W-1:0];
`endif
  end

  // Capture control: next state, cycle counter, halt reason, sticky overflow.
  always_comb begin
    state_d       = state_q;
    cyc_d         = cyc_q;
    halt_reason_d = halt_reason_q;
    overflow_d    = overflow_q;

    unique case (state_q)
      ST_IDLE, ST_HALT: begin
        // Re-arming keeps buffered entries; only run status is cleared.
        if (arm) begin
          state_d       = ST_RUN;
          cyc_d         = '0;
          halt_reason_d = HR_NONE;
          overflow_d    = 1'b0;
        end
      end
      ST_RUN: begin
        cyc_d = cyc_inc_c;
        if (overwrite_c) begin
          overflow_d = 1'b1;
        end
        // Halt priority: halt instruction, then full drop, then cycle limit.
        if (push_c && (bus.commit_instr == HALT_INSTR)) begin
          state_d       = ST_HALT;
          halt_reason_d = HR_HALT_INSTR;
        end else if (drop_c) begin
          state_d       = ST_HALT;
          halt_reason_d = HR_FULL;
        end else if (cyc_inc_c == CYC_W'(CYCLE_LIMIT)) begin
          state_d       = ST_HALT;
          halt_reason_d = HR_LIMIT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    running_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= ST_IDLE;
      cyc_q         <= '0;
      halt_reason_q <= HR_NONE;
      overflow_q    <= 1'b0;
      running_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cyc_q         <= cyc_d;
      halt_reason_q <= halt_reason_d;
      overflow_q    <= overflow_d;
      running_q     <= running_d;
    end
  end

  trace_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH),
    .WRAP  (WRAP)
  ) u_fifo (
    .clk         (clk),
    .rstn        (rstn),
    .push        (push_c),
    .push_data   (entry_c),
    .pop         (bus.rd_en),
    .rd_valid    (fifo_rd_valid),
    .rd_data     (fifo_rd_data),
    .count       (count),
    .drop_c      (drop_c),
    .overwrite_c (overwrite_c)
  );

  assign bus.rd_valid = fifo_rd_valid;
  assign bus.rd_data  = fifo_rd_data;
  assign running      = running_q;
  assign halt_reason  = halt_reason_q;
  assign overflow     = overflow_q;

endmodule
